// File: rtl/geofence_pkg.sv
// geofence_pkg: shared coordinate, operation and orientation types for the
// geofence cross-product arbiter slice.
package geofence_pkg;
   localparam int CW = 10;
   typedef logic [CW-1:0] coord_t;
   typedef struct packed {
      coord_t ax;
      coord_t ay;
      coord_t bx;
      coord_t by;
      coord_t cx;
      coord_t cy;
   } op_t;
   typedef enum logic [1:0] {NEG = 2'd0, ZERO = 2'd1, POS = 2'd2} orient_e;
   typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_e;
endpackage

// File: rtl/geofence_cross_core.sv
// geofence_cross_core: pipelined orientation engine, sign/zero of (A-C)x(B-C);
// stage 1 holds the differences, stage 2 the compare, further stages only delay.
module geofence_cross_core
   import geofence_pkg::*;
#(
   parameter int CW  = geofence_pkg::CW,
   parameter int LAT = 2,
   parameter int TW  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [TW-1:0]   in_tag,
   input  logic [6*CW-1:0] in_op,
   output logic            out_valid,
   output logic [TW-1:0]   out_tag,
   output logic            out_pos,
   output logic            out_zero,
   output logic            busy
);
   localparam int ND = (LAT > 1) ? LAT - 1 : 1;
   localparam int DW = CW + 1;
   localparam int SW = 1 + TW + 4 * DW;
   logic [CW-1:0]          w_ax, w_ay, w_bx, w_by, w_cx, w_cy;
   logic signed [DW-1:0]   w_dx1, w_dy1, w_dx2, w_dy2;
   logic signed [DW-1:0]   w_sx1, w_sy1, w_sx2, w_sy2;
   logic [SW-1:0]          w_st1, r_st1;
   logic                   w_sv;
   logic [TW-1:0]          w_st;
   logic signed [2*DW-1:0] w_m1, w_m2;
   orient_e                w_orient;
   logic [ND-1:0]          r_v;
   logic [ND-1:0][TW-1:0]  r_tag;
   logic [ND-1:0][1:0]     r_or;

   assign {w_ax, w_ay, w_bx, w_by, w_cx, w_cy} = in_op;
   assign w_dx1 = DW'(w_ax) - DW'(w_cx);
   assign w_dy1 = DW'(w_ay) - DW'(w_cy);
   assign w_dx2 = DW'(w_bx) - DW'(w_cx);
   assign w_dy2 = DW'(w_by) - DW'(w_cy);
   assign w_st1 = {in_valid, in_tag, w_dx1, w_dy1, w_dx2, w_dy2};
   // With LAT=1 the difference stage collapses into the compare stage
   assign {w_sv, w_st, w_sx1, w_sy1, w_sx2, w_sy2} = (LAT > 1) ? r_st1 : w_st1;
   assign w_m1 = w_sx1 * w_sy2;
   assign w_m2 = w_sx2 * w_sy1;
   assign w_orient = (w_m1 > w_m2) ? POS : (w_m1 == w_m2) ? ZERO : NEG;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_st1 <= '0;
         r_v   <= '0;
         r_tag <= '0;
         r_or  <= '0;
      end else begin
         r_st1    <= w_st1;
         r_v[0]   <= w_sv;
         r_tag[0] <= w_st;
         r_or[0]  <= w_orient;
         for (int i = 1; i < ND; i++) begin
            r_v[i]   <= r_v[i-1];
            r_tag[i] <= r_tag[i-1];
            r_or[i]  <= r_or[i-1];
         end
      end
   end

   assign out_valid = r_v[ND-1];
   assign out_tag   = r_tag[ND-1];
   assign out_pos   = r_or[ND-1] == POS;
   assign out_zero  = r_or[ND-1] == ZERO;
   assign busy      = (|r_v) | ((LAT > 1) && r_st1[SW-1]);
endmodule

// File: rtl/geofence_cross_arbiter.sv
// geofence_cross_arbiter: round-robin arbiter with burst lock sharing one
// orientation engine; results return tagged one-hot to the granted requester.
module geofence_cross_arbiter
   import geofence_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int CW        = geofence_pkg::CW,
   parameter int LAT       = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_lock,
   input  logic [NREQ*6*CW-1:0]   req_ops,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        resp_valid,
   output logic                   resp_pos,
   output logic                   resp_zero,
   output logic                   busy
);
   localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
   arb_state_e      r_state, w_state;
   logic [TW-1:0]   r_owner, w_owner, r_rr, w_rr, w_win, w_idx, w_out_tag;
   logic [3:0]      r_burst, w_burst;
   logic            w_gnt, w_out_valid;
   logic [6*CW-1:0] w_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_rr    <= '0;
         r_burst <= '0;
      end else begin
         r_state <= w_state;
         r_owner <= w_owner;
         r_rr    <= w_rr;
         r_burst <= w_burst;
      end
   end

   // An owned requester that drops valid forfeits the lock without a grant
   always_comb begin
      w_state = r_state;
      w_owner = r_owner;
      w_burst = r_burst;
      w_rr    = r_rr;
      if (w_gnt)
         w_rr = (w_win == TW'(NREQ - 1)) ? '0 : w_win + TW'(1);
      if (r_state == IDLE) begin
         if (w_gnt && req_lock[w_win] && MAX_BURST > 1) begin
            w_state = OWNED;
            w_owner = w_win;
            w_burst = 4'd1;
         end
      end else if (!req_valid[r_owner] || !req_lock[r_owner] || r_burst + 4'd1 >= 4'(MAX_BURST))
         w_state = IDLE;
      else
         w_burst = r_burst + 4'd1;
   end

   // Lowest rotated offset from the pointer wins, so scan from the far end
   always_comb begin
      w_gnt = 1'b0;
      w_win = r_owner;
      w_idx = '0;
      if (r_state == OWNED)
         w_gnt = req_valid[r_owner];
      else
         for (int j = NREQ - 1; j >= 0; j--) begin
            w_idx = TW'((int'(r_rr) + j) % NREQ);
            if (req_valid[w_idx]) begin
               w_gnt = 1'b1;
               w_win = w_idx;
            end
         end
      req_ready = w_gnt ? (ONE << w_win) : '0;
   end

   assign w_op = req_ops[int'(w_win) * 6 * CW +: 6 * CW];

   geofence_cross_core #(.CW(CW), .LAT(LAT), .TW(TW)) u_core (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (w_gnt),
      .in_tag    (w_win),
      .in_op     (w_op),
      .out_valid (w_out_valid),
      .out_tag   (w_out_tag),
      .out_pos   (resp_pos),
      .out_zero  (resp_zero),
      .busy      (busy)
   );

   assign resp_valid = w_out_valid ? (ONE << w_out_tag) : '0;
endmodule
